echo_indication_serializer: RTL and testbench

//  Downstream stage of the echo indication output packer. Accepts 96-bit packed

---
 rtl/echo_pkg.sv | 29 ++
 rtl/echo_indication_serializer_msg_fifo.sv | 60 ++++++
 rtl/echo_indication_serializer.sv | 87 ++++++++
 tb/tb_echo_indication_serializer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// Shared constants and types for the echo indication serializer.
// Message layout {v, meth, tag}, word-index encoding, header builder.
package echo_pkg;

   localparam int MSG_WIDTH  = 96;
   localparam int WORD_WIDTH = 32;
   localparam int MSG_WORDS  = 3;

   localparam int TAG_LSB  = 0;
   localparam int METH_LSB = 32;
   localparam int V_LSB    = 64;

   localparam int HDR_TAG_W = 16;
   localparam int HDR_LEN_W = 16;

   typedef enum logic [1:0] {
      IDX_HDR  = 2'd0,
      IDX_METH = 2'd1,
      IDX_V    = 2'd2
   } word_idx_e;

   // Header: constant length field over the low half of the tag.
   function automatic logic [WORD_WIDTH-1:0] hdr_word(
      input logic [MSG_WIDTH-1:0] msg
   );
      return {HDR_LEN_W'(MSG_WORDS), msg[TAG_LSB +: HDR_TAG_W]};
   endfunction

endpackage

// File: rtl/echo_indication_serializer_msg_fifo.sv
// Synchronous DEPTH x 96 message FIFO.
// Ports: clk, rst, push/data_in, pop/head, count, full, empty.
module msg_fifo
   import echo_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [MSG_WIDTH-1:0]       data_in,
   input  logic                       pop,
   output logic [MSG_WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [MSG_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     wptr;
   logic [PTR_W-1:0]     rptr;
   logic [CNT_W-1:0]     cnt;
   logic                 push_ok;
   logic                 pop_ok;

   assign full    = (cnt == CNT_W'(DEPTH));
   assign empty   = (cnt == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rptr];
   assign count   = cnt;

   // Pointers wrap naturally; cnt tells full from empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push_ok)
            wptr <= wptr + 1'b1;
         if (pop_ok)
            rptr <= rptr + 1'b1;
         unique case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wptr] <= data_in;
   end

endmodule

// File: rtl/echo_indication_serializer.sv
// Buffers 96-bit indication messages and emits each as header + 2 words.
// Ports: CLK, RST, pipe_enq (ENA/v/RDY), out_word (ENA/v/last/RDY), count.
module echo_indication_serializer
   import echo_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    pipe_enq__ENA,
   input  logic [MSG_WIDTH-1:0]    pipe_enq_v,
   output logic                    pipe_enq__RDY,
   output logic                    out_word__ENA,
   output logic [WORD_WIDTH-1:0]   out_word_v,
   output logic                    out_word_last,
   input  logic                    out_word__RDY,
   output logic [$clog2(DEPTH):0]  count
);

   logic [MSG_WIDTH-1:0] head;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic                 xfer;
   word_idx_e            idx;
   word_idx_e            idx_nxt;

   // Gating by RST keeps both handshakes quiet while in reset.
   assign pipe_enq__RDY = ~RST & ~full;
   assign out_word__ENA = ~RST & ~empty;

   assign push = pipe_enq__ENA & pipe_enq__RDY;
   assign xfer = out_word__ENA & out_word__RDY;
   assign pop  = xfer & (idx == IDX_V);

   msg_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .push    (push),
      .data_in (pipe_enq_v),
      .pop     (pop),
      .head    (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge CLK) begin
      if (RST)
         idx <= IDX_HDR;
      else
         idx <= idx_nxt;
   end

   always_comb begin
      idx_nxt = idx;
      if (xfer) begin
         unique case (idx)
            IDX_HDR:  idx_nxt = IDX_METH;
            IDX_METH: idx_nxt = IDX_V;
            IDX_V:    idx_nxt = IDX_HDR;
            default:  idx_nxt = IDX_HDR;
         endcase
      end
   end

   // Word mux; forced to zero whenever no word is offered.
   always_comb begin
      out_word_v    = '0;
      out_word_last = 1'b0;
      if (out_word__ENA) begin
         unique case (idx)
            IDX_HDR:  out_word_v = hdr_word(head);
            IDX_METH: out_word_v = head[METH_LSB +: WORD_WIDTH];
            IDX_V: begin
               out_word_v    = head[V_LSB +: WORD_WIDTH];
               out_word_last = 1'b1;
            end
            default:  out_word_v = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_echo_indication_serializer.sv
// Directed bench for echo_indication_serializer.
// Vector table for reset/single/back-pressure plus hand sequences.
module tb_echo_indication_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        enq_ena;
   logic [95:0] enq_v;
   logic        enq_rdy;
   logic        w_ena;
   logic [31:0] w_v;
   logic        w_last;
   logic        w_rdy;
   logic [2:0]  cnt;

   int n_vec = 0;
   int n_bad = 0;
   int proto_err = 0;

   always #5 clk = ~clk;

   echo_indication_serializer #(.DEPTH(4)) dut (
      .CLK           (clk),
      .RST           (rst),
      .pipe_enq__ENA (enq_ena),
      .pipe_enq_v    (enq_v),
      .pipe_enq__RDY (enq_rdy),
      .out_word__ENA (w_ena),
      .out_word_v    (w_v),
      .out_word_last (w_last),
      .out_word__RDY (w_rdy),
      .count         (cnt)
   );

   // Enqueue while not ready is a protocol error: record it.
   always @(posedge clk)
      if (!rst && enq_ena && !enq_rdy)
         proto_err++;

   typedef struct {
      logic        rst;
      logic        ena;
      logic [95:0] v;
      logic        rdy;
      logic        erdy;
      logic        eena;
      logic [31:0] ew;
      logic        elast;
      logic [2:0]  ecnt;
   } vec_t;

   vec_t tbl [19];

   function automatic logic [95:0] msg(
      input logic [31:0] v, input logic [31:0] m, input logic [31:0] t);
      return {v, m, t};
   endfunction

   function automatic logic [31:0] part(input logic [95:0] m, input int k);
      if (k == 0) return {16'd3, m[15:0]};
      if (k == 1) return m[63:32];
      return m[95:64];
   endfunction

   function automatic vec_t mk(
      input logic r, input logic e, input logic [95:0] v, input logic s,
      input logic erdy, input logic eena, input logic [31:0] ew,
      input logic elast, input logic [2:0] ecnt);
      vec_t x;
      x.rst = r; x.ena = e; x.v = v; x.rdy = s;
      x.erdy = erdy; x.eena = eena; x.ew = ew;
      x.elast = elast; x.ecnt = ecnt;
      return x;
   endfunction

   task automatic chk(input string name, input logic erdy, input logic eena,
                      input logic [31:0] ew, input logic elast,
                      input logic [2:0] ecnt);
      n_vec++;
      if (enq_rdy !== erdy || w_ena !== eena || w_v !== ew ||
          w_last !== elast || cnt !== ecnt) begin
         n_bad++;
         $display("FAIL %s: got rdy=%b ena=%b v=%h last=%b cnt=%0d, want rdy=%b ena=%b v=%h last=%b cnt=%0d",
                  name, enq_rdy, w_ena, w_v, w_last, cnt,
                  erdy, eena, ew, elast, ecnt);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic [95:0] v,
                        input logic s);
      @(negedge clk);
      rst = r; enq_ena = e; enq_v = v; w_rdy = s;
      #1;
   endtask

   logic [95:0] m1, m2, ms [5], mc [3], m6a, m6b;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      m1 = msg(32'hDEADBEEF, 32'h5, 32'h1);
      m2 = msg(32'h12345678, 32'h5, 32'hABCD0002);

      // reset held with ENA high
      tbl[0]  = mk(1, 1, m1, 1, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 1, m1, 1, 0, 0, 0, 0, 0);
      tbl[2]  = mk(1, 1, m1, 1, 0, 0, 0, 0, 0);
      tbl[3]  = mk(0, 0, 0,  1, 1, 0, 0, 0, 0);
      // single message, sink ready
      tbl[4]  = mk(0, 1, m1, 1, 1, 0, 0, 0, 0);
      tbl[5]  = mk(0, 0, 0,  1, 1, 1, 32'h00030001, 0, 1);
      tbl[6]  = mk(0, 0, 0,  1, 1, 1, 32'h00000005, 0, 1);
      tbl[7]  = mk(0, 0, 0,  1, 1, 1, 32'hDEADBEEF, 1, 1);
      tbl[8]  = mk(0, 0, 0,  1, 1, 0, 0, 0, 0);
      // back-pressure during the meth word
      tbl[9]  = mk(0, 1, m2, 0, 1, 0, 0, 0, 0);
      tbl[10] = mk(0, 0, 0,  1, 1, 1, 32'h00030002, 0, 1);
      for (int i = 11; i < 16; i++)
         tbl[i] = mk(0, 0, 0, 0, 1, 1, 32'h00000005, 0, 1);
      tbl[16] = mk(0, 0, 0,  1, 1, 1, 32'h00000005, 0, 1);
      tbl[17] = mk(0, 0, 0,  1, 1, 1, 32'h12345678, 1, 1);
      tbl[18] = mk(0, 0, 0,  1, 1, 0, 0, 0, 0);

      rst = 1; enq_ena = 0; enq_v = 0; w_rdy = 1;
      @(posedge clk);

      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].rst, tbl[i].ena, tbl[i].v, tbl[i].rdy);
         chk($sformatf("vec%0d", i), tbl[i].erdy, tbl[i].eena,
             tbl[i].ew, tbl[i].elast, tbl[i].ecnt);
      end

      // fill with sink stalled, 5th enqueue ignored, then drain
      for (int i = 0; i < 5; i++)
         ms[i] = msg(32'hA0000000 + i, 32'hB0000000 + i, 32'h00000100 + i);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, ms[i], 0);
         chk($sformatf("fill%0d", i), 1, i > 0,
             (i > 0) ? part(ms[0], 0) : 32'h0, 0, 3'(i));
      end
      drive(0, 1, ms[4], 0);
      chk("full", 0, 1, part(ms[0], 0), 0, 4);
      for (int k = 0; k < 12; k++) begin
         drive(0, 0, 0, 1);
         chk($sformatf("drain%0d", k), (4 - k / 3) != 4, 1,
             part(ms[k / 3], k % 3), (k % 3) == 2, 3'(4 - k / 3));
      end
      drive(0, 0, 0, 1);
      chk("drained", 1, 0, 0, 0, 0);
      n_vec++;
      if (proto_err != 1) begin
         n_bad++;
         $display("FAIL proto_flag: got %0d errors, want 1", proto_err);
      end

      // push lands exactly on the popping transfer
      for (int i = 0; i < 3; i++)
         mc[i] = msg(32'hC0000000 + i, 32'hD0000000 + i, 32'h00000200 + i);
      drive(0, 1, mc[0], 0);
      chk("cc_push0", 1, 0, 0, 0, 0);
      drive(0, 1, mc[1], 0);
      chk("cc_push1", 1, 1, part(mc[0], 0), 0, 1);
      for (int k = 0; k < 9; k++) begin
         drive(0, k == 2, (k == 2) ? mc[2] : 96'h0, 1);
         chk($sformatf("cc%0d", k), 1, 1, part(mc[k / 3], k % 3),
             (k % 3) == 2, (k < 6) ? 3'd2 : 3'd1);
      end
      drive(0, 0, 0, 1);
      chk("cc_done", 1, 0, 0, 0, 0);

      // reset after the header of a message went out
      m6a = msg(32'h11111111, 32'h22222222, 32'h00000033);
      m6b = msg(32'h44444444, 32'h55555555, 32'hFFFF0066);
      drive(0, 1, m6a, 1);
      chk("mr_push", 1, 0, 0, 0, 0);
      drive(0, 0, 0, 1);
      chk("mr_hdr", 1, 1, part(m6a, 0), 0, 1);
      drive(1, 0, 0, 1);
      chk("mr_rst", 0, 0, 0, 0, 1);
      drive(0, 1, m6b, 1);
      chk("mr_after", 1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 1);
         chk($sformatf("mr_w%0d", k), 1, 1, part(m6b, k), k == 2, 1);
      end
      drive(0, 0, 0, 1);
      chk("mr_done", 1, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
